// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display scheduler slice.
package display_sched_pkg;

  typedef enum logic {
    S_SCAN  = 1'b0,
    S_ALERT = 1'b1
  } state_e;

  // 1 s dwell and 2 s alert hold at a 50 MHz CLOCK_50.
  localparam int DEF_DWELL_CYCLES = 50_000_000;
  localparam int DEF_HOLD_CYCLES  = 100_000_000;

  // Bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Bus between the value sources and the display scheduler.
// Handshake: alert_req is a level request held by source k; the scheduler
// answers with a single-cycle alert_ack[k] pulse when it grants k. The
// requester must drop alert_req after its ack; a request still high once the
// alert hold ends is treated as a brand-new request.
interface display_scheduler_if
  import display_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = clog2(NUM_SRC)
);
  logic [NUM_SRC*32-1:0] src_value;
  logic [NUM_SRC-1:0]    src_valid;
  logic                  mode_auto;
  logic [SRC_W-1:0]      manual_sel;
  logic                  freeze;
  logic [NUM_SRC-1:0]    alert_req;
  logic [NUM_SRC-1:0]    alert_ack;
  logic [31:0]           number_to_show;
  logic [SRC_W-1:0]      active_src;
  logic                  alert_active;
  logic                  update_strobe;
  state_e                state_dbg;

  modport master (
    output src_value, src_valid, mode_auto, manual_sel, freeze, alert_req,
    input  alert_ack, number_to_show, active_src, alert_active, update_strobe,
           state_dbg
  );

  modport slave (
    input  src_value, src_valid, mode_auto, manual_sel, freeze, alert_req,
    output alert_ack, number_to_show, active_src, alert_active, update_strobe,
           state_dbg
  );
endinterface

// File: rtl/display_scheduler_rr_picker.sv
// Circular find-first-set: first set bit of req_i at or after start_i.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = W'((int'(start_i) + i) % N);
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end
endmodule

// File: rtl/display_scheduler.sv
// Time-shares the decimal display among NUM_SRC sources: auto-rotate,
// manual select, freeze, and pre-emptive round-robin alerts.
// Macro DISPLAY_SCHED_ALERT_EN: when defined, the alert path is built;
// otherwise alert_req is ignored and alert outputs are tied low.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input logic                CLOCK_50,
  input logic                RST_N,
  display_scheduler_if.slave bus
);
  localparam int SRC_W = clog2(NUM_SRC);

  logic [31:0]      num_q, num_d;
  logic [SRC_W-1:0] active_q, active_d;
  logic [31:0]      dwell_q, dwell_d;
  logic             strobe_q, strobe_d;

  logic [SRC_W-1:0] scan_active;
  logic [31:0]      scan_dwell;
  logic [31:0]      scan_num;
  logic [SRC_W-1:0] rot_start, rot_idx;
  logic             rot_found;

  // Searching from active_src+1 returns active_src itself only when no
  // other source is valid, which leaves the selection unchanged.
  assign rot_start = active_q + 1'b1;

  rr_picker #(.N(NUM_SRC), .W(SRC_W)) u_rotate (
    .req_i   (bus.src_valid),
    .start_i (rot_start),
    .found_o (rot_found),
    .idx_o   (rot_idx)
  );

  // Next selection, dwell count and shown value while scanning.
  always_comb begin
    scan_active = active_q;
    scan_dwell  = dwell_q;
    scan_num    = num_q;
    if (!bus.freeze) begin
      if (bus.mode_auto) begin
        if (dwell_q == 32'(DWELL_CYCLES - 1)) begin
          scan_dwell = '0;
          if (rot_found) scan_active = rot_idx;
        end else begin
          scan_dwell = dwell_q + 32'd1;
        end
      end else begin
        scan_dwell = '0;
        if (32'(bus.manual_sel) < 32'(NUM_SRC)) scan_active = bus.manual_sel;
      end
      if (bus.src_valid[scan_active]) scan_num = bus.src_value[{scan_active, 5'b0} +: 32];
    end
  end

  // Display-side registers shared by both builds.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      num_q    <= '0;
      active_q <= '0;
      dwell_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      num_q    <= num_d;
      active_q <= active_d;
      dwell_q  <= dwell_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.number_to_show = num_q;
  assign bus.active_src     = active_q;
  assign bus.update_strobe  = strobe_q;

`ifdef DISPLAY_SCHED_ALERT_EN
  state_e             state_q, state_d;
  logic [31:0]        hold_q, hold_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [SRC_W-1:0]   saved_q, saved_d;
  logic               alert_q, alert_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_found;

  rr_picker #(.N(NUM_SRC), .W(SRC_W)) u_grant (
    .req_i   (bus.alert_req),
    .start_i (rr_q),
    .found_o (grant_found),
    .idx_o   (grant_idx)
  );

  // Scan/alert FSM: alert entry beats rotation, manual select and freeze.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    num_d    = num_q;
    dwell_d  = dwell_q;
    strobe_d = 1'b0;
    hold_d   = hold_q;
    rr_d     = rr_q;
    saved_d  = saved_q;
    alert_d  = alert_q;
    ack_d    = '0;
    case (state_q)
      S_SCAN: begin
        if (grant_found) begin
          state_d  = S_ALERT;
          saved_d  = active_q;
          active_d = grant_idx;
          num_d    = bus.src_value[{grant_idx, 5'b0} +: 32];
          ack_d    = NUM_SRC'(1) << grant_idx;
          alert_d  = 1'b1;
          strobe_d = 1'b1;
          hold_d   = '0;
          rr_d     = (32'(grant_idx) == 32'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
          active_d = scan_active;
          num_d    = scan_num;
          dwell_d  = scan_dwell;
          strobe_d = (scan_active != active_q);
        end
      end
      S_ALERT: begin
        if (hold_q == 32'(HOLD_CYCLES - 1)) begin
          state_d  = S_SCAN;
          active_d = saved_q;
          alert_d  = 1'b0;
          dwell_d  = '0;
          strobe_d = 1'b1;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  // Alert-path state; reset aborts an alert without an ack.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q <= S_SCAN;
      hold_q  <= '0;
      rr_q    <= '0;
      saved_q <= '0;
      alert_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
      saved_q <= saved_d;
      alert_q <= alert_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.alert_ack    = ack_q;
  assign bus.alert_active = alert_q;
  assign bus.state_dbg    = state_q;
`else
  // Scan-only build: the scan proposal is the next state.
  always_comb begin
    active_d = scan_active;
    num_d    = scan_num;
    dwell_d  = scan_dwell;
    strobe_d = (scan_active != active_q);
  end

  assign bus.alert_ack    = '0;
  assign bus.alert_active = 1'b0;
  assign bus.state_dbg    = S_SCAN;
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (NUM_SRC=4 main instance plus a
// NUM_SRC=3 instance for the out-of-range manual select).
module tb_display_scheduler;
  import display_sched_pkg::*;

  localparam int W = 40;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  display_scheduler_if #(.NUM_SRC(4)) bus_a ();
  display_scheduler_if #(.NUM_SRC(3)) bus_b ();

  display_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(4), .HOLD_CYCLES(8)) dut_a (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .bus      (bus_a)
  );

  display_scheduler #(.NUM_SRC(3), .DWELL_CYCLES(4), .HOLD_CYCLES(8)) dut_b (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .bus      (bus_b)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        au;
    logic [1:0]  sel;
    logic        frz;
    logic [3:0]  req;
    logic [1:0]  e_active;
    logic [31:0] e_num;
    logic        e_strobe;
    logic        e_alert;
    logic [3:0]  e_ack;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];

  function automatic logic [31:0] val(input int k);
    return 32'h1111 * 32'(k + 1);
  endfunction

  function automatic void add(input int rst, input int valid, input int au, input int sel,
                              input int frz, input int req, input int ea, input logic [31:0] en,
                              input int es, input int eal, input int eack);
    vec_t v;
    v.rst = 1'(rst);      v.valid = 4'(valid); v.au = 1'(au);       v.sel = 2'(sel);
    v.frz = 1'(frz);      v.req = 4'(req);     v.e_active = 2'(ea); v.e_num = en;
    v.e_strobe = 1'(es);  v.e_alert = 1'(eal); v.e_ack = 4'(eack);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    logic [W-1:0] e;
    int rot_seq[3];

    rst_n = 1'b0;
    bus_a.src_value  = {val(3), val(2), val(1), val(0)};
    bus_a.src_valid  = 4'hF;
    bus_a.mode_auto  = 1'b0;
    bus_a.manual_sel = 2'd0;
    bus_a.freeze     = 1'b0;
    bus_a.alert_req  = 4'h0;
    bus_b.src_value  = {val(2), val(1), val(0)};
    bus_b.src_valid  = 3'b111;
    bus_b.mode_auto  = 1'b0;
    bus_b.manual_sel = 2'd0;
    bus_b.freeze     = 1'b0;
    bus_b.alert_req  = 3'b000;

    // Reset with arbitrary inputs.
    for (int k = 0; k < 2; k++)
      add(0, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 15), 0, 32'h0, 0, 0, 0);

    // Auto rotation over all four sources, 4 cycles each, wrapping 3 -> 0.
    for (int k = 0; k < 3; k++) add(1, 4'hF, 1, 0, 0, 0, 0, val(0), 0, 0, 0);
    for (int s = 1; s <= 4; s++) begin
      add(1, 4'hF, 1, 0, 0, 0, s % 4, val(s % 4), 1, 0, 0);
      if (s < 4)
        for (int k = 0; k < 3; k++) add(1, 4'hF, 1, 0, 0, 0, s, val(s), 0, 0, 0);
    end

    // Sparse valid set 1010: invalid source 0 keeps the old value, rotation skips.
    for (int k = 0; k < 3; k++) add(1, 4'hA, 1, 0, 0, 0, 0, val(0), 0, 0, 0);
    rot_seq = '{1, 3, 1};
    for (int s = 0; s < 3; s++) begin
      add(1, 4'hA, 1, 0, 0, 0, rot_seq[s], val(rot_seq[s]), 1, 0, 0);
      for (int k = 0; k < 3; k++) add(1, 4'hA, 1, 0, 0, 0, rot_seq[s], val(rot_seq[s]), 0, 0, 0);
    end
    // Only the active source valid: rotation point passes with no change.
    for (int k = 0; k < 5; k++) add(1, 4'h2, 1, 0, 0, 0, 1, val(1), 0, 0, 0);

    // Manual select, freeze, and selecting an invalid source.
    add(1, 4'hF, 0, 2, 0, 0, 2, val(2), 1, 0, 0);
    add(1, 4'hF, 0, 2, 0, 0, 2, val(2), 0, 0, 0);
    add(1, 4'hF, 0, 0, 1, 0, 2, val(2), 0, 0, 0);
    add(1, 4'hF, 0, 0, 0, 0, 0, val(0), 1, 0, 0);
    add(1, 4'h7, 0, 3, 0, 0, 3, val(0), 1, 0, 0);
    add(1, 4'hF, 0, 3, 0, 0, 3, val(3), 0, 0, 0);
    // Freeze in auto mode holds the dwell counter past the dwell length.
    for (int k = 0; k < 6; k++) add(1, 4'hF, 1, 0, 1, 0, 3, val(3), 0, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 4'hF, 1, 0, 0, 0, 3, val(3), 0, 0, 0);
    add(1, 4'hF, 1, 0, 0, 0, 0, val(0), 1, 0, 0);

`ifdef DISPLAY_SCHED_ALERT_EN
    // Held requests 1010: grant 1, hold 8, one scan cycle, then grant 3.
    add(1, 4'hF, 0, 0, 0, 4'hA, 1, val(1), 1, 1, 4'b0010);
    for (int k = 0; k < 7; k++) add(1, 4'hF, 0, 0, 0, 4'hA, 1, val(1), 0, 1, 0);
    add(1, 4'hF, 0, 0, 0, 4'hA, 0, val(1), 1, 0, 0);
    add(1, 4'hF, 0, 0, 0, 4'hA, 3, val(3), 1, 1, 4'b1000);
    for (int k = 0; k < 7; k++) add(1, 4'hF, 0, 0, 0, 0, 3, val(3), 0, 1, 0);
    add(1, 4'hF, 0, 0, 0, 0, 0, val(3), 1, 0, 0);
    add(1, 4'hF, 0, 0, 0, 0, 0, val(0), 0, 0, 0);
    // Alert beats freeze; reset at hold_cnt=3 aborts it.
    add(1, 4'hF, 0, 0, 1, 4'b0100, 2, val(2), 1, 1, 4'b0100);
    for (int k = 0; k < 3; k++) add(1, 4'hF, 0, 0, 0, 0, 2, val(2), 0, 1, 0);
    add(0, 4'hF, 0, 0, 0, 4'b0100, 0, 32'h0, 0, 0, 0);
    add(1, 4'hF, 0, 0, 0, 0, 0, val(0), 0, 0, 0);
    // Round-robin pointer restarts at 0 after reset.
    add(1, 4'hF, 0, 0, 0, 4'hF, 0, val(0), 1, 1, 4'b0001);
    for (int k = 0; k < 7; k++) add(1, 4'hF, 0, 0, 0, 0, 0, val(0), 0, 1, 0);
    add(1, 4'hF, 0, 0, 0, 0, 0, val(0), 1, 0, 0);
`else
    // Alert path absent: requests have no effect.
    for (int k = 0; k < 4; k++) add(1, 4'hF, 0, 0, 0, 4'hA, 0, val(0), 0, 0, 0);
    add(1, 4'hF, 0, 0, 1, 4'b0100, 0, val(0), 0, 0, 0);
    add(0, 4'hF, 0, 0, 0, 4'b0100, 0, 32'h0, 0, 0, 0);
    add(1, 4'hF, 0, 0, 0, 4'hF, 0, val(0), 0, 0, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n            = vecs[i].rst;
      bus_a.src_valid  = vecs[i].valid;
      bus_a.mode_auto  = vecs[i].au;
      bus_a.manual_sel = vecs[i].sel;
      bus_a.freeze     = vecs[i].frz;
      bus_a.alert_req  = vecs[i].req;
      exp_q.push_back({vecs[i].e_active, vecs[i].e_num, vecs[i].e_strobe,
                       vecs[i].e_alert, vecs[i].e_ack});
      tick();
      e = exp_q.pop_front();
      check($sformatf("row%0d active_src", i), 64'(bus_a.active_src), 64'(e[39:38]));
      check($sformatf("row%0d number_to_show", i), 64'(bus_a.number_to_show), 64'(e[37:6]));
      check($sformatf("row%0d update_strobe", i), 64'(bus_a.update_strobe), 64'(e[5]));
      check($sformatf("row%0d alert_active", i), 64'(bus_a.alert_active), 64'(e[4]));
      check($sformatf("row%0d alert_ack", i), 64'(bus_a.alert_ack), 64'(e[3:0]));
      check($sformatf("row%0d state", i), 64'(bus_a.state_dbg),
            64'(e[4] ? S_ALERT : S_SCAN));
    end
    bus_a.alert_req = 4'h0;

    // NUM_SRC=3 instance: out-of-range manual select and 2 -> 0 wrap.
    bus_b.manual_sel = 2'd1;
    tick();
    check("b_sel1 active_src", 64'(bus_b.active_src), 64'd1);
    check("b_sel1 number_to_show", 64'(bus_b.number_to_show), 64'(val(1)));
    check("b_sel1 update_strobe", 64'(bus_b.update_strobe), 64'd1);
    bus_b.manual_sel = 2'd3;
    tick();
    check("b_sel3 active_src", 64'(bus_b.active_src), 64'd1);
    check("b_sel3 number_to_show", 64'(bus_b.number_to_show), 64'(val(1)));
    check("b_sel3 update_strobe", 64'(bus_b.update_strobe), 64'd0);
    bus_b.manual_sel = 2'd2;
    tick();
    check("b_sel2 active_src", 64'(bus_b.active_src), 64'd2);
    check("b_sel2 number_to_show", 64'(bus_b.number_to_show), 64'(val(2)));
    bus_b.mode_auto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("b_auto%0d active_src", k), 64'(bus_b.active_src), 64'd2);
    end
    tick();
    check("b_wrap active_src", 64'(bus_b.active_src), 64'd0);
    check("b_wrap number_to_show", 64'(bus_b.number_to_show), 64'(val(0)));
    check("b_wrap update_strobe", 64'(bus_b.update_strobe), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
